pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_pkg.sv | 12 +
 rtl/fwd_select.sv | 40 ++++
 rtl/pipe_hazard_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/pipe_hazard_pkg.sv
// rtl/pipe_hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DMISS = 2'd2
    } hz_state_e;

    localparam int FWD_RF = 0;

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - forwarding source select and load-use hazard for one source operand
module fwd_select
    import pipe_hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 2,
    parameter int SELW       = 2
) (
    input  logic [REG_AW-1:0]            i_rs,
    input  logic                         i_need,
    input  logic [FWD_STAGES*REG_AW-1:0] i_prod_rd,
    input  logic [FWD_STAGES-1:0]        i_prod_we,
    input  logic [FWD_STAGES-1:0]        i_prod_rdy,
    output logic [SELW-1:0]              o_sel,
    output logic                         o_hazard
);

    logic            w_hit;
    logic            w_rdy;
    logic [SELW-1:0] w_sel;

    // Scan oldest to youngest so the youngest matching producer wins.
    always_comb begin
        w_hit = 1'b0;
        w_rdy = 1'b0;
        w_sel = SELW'(FWD_RF);
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (i_need && i_prod_we[k-1] && (i_rs != '0) &&
                (i_prod_rd[(k-1)*REG_AW +: REG_AW] == i_rs)) begin
                w_hit = 1'b1;
                w_rdy = i_prod_rdy[k-1];
                w_sel = SELW'(k);
            end
        end
    end

    assign o_hazard = w_hit & ~w_rdy;
    assign o_sel    = o_hazard ? SELW'(FWD_RF) : w_sel;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - operand forwarding, stall and flush control for an in-order pipeline
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int FLUSH_CYC  = 1,
    localparam int SELW      = $clog2(FWD_STAGES + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_SRC*REG_AW-1:0]    i_rs_addr,
    input  logic [NUM_SRC-1:0]           i_rs_need,
    input  logic [FWD_STAGES*REG_AW-1:0] i_prod_rd,
    input  logic [FWD_STAGES-1:0]        i_prod_we,
    input  logic [FWD_STAGES-1:0]        i_prod_rdy,
    input  logic                         i_mispredict,
    input  logic                         i_dcache_miss,
    input  logic                         i_icache_miss,
    output logic [NUM_SRC*SELW-1:0]      o_fwd_sel,
    output logic                         o_pc_stall,
    output logic                         o_ifid_stall,
    output logic                         o_idex_stall,
    output logic                         o_exma_stall,
    output logic                         o_ifid_flush,
    output logic                         o_idex_flush,
    output logic                         o_exma_flush,
    output logic                         o_mawb_flush,
    output logic [31:0]                  o_stall_cnt
);

    localparam int         FCNT_I    = (FLUSH_CYC > 1) ? FLUSH_CYC - 2 : 0;
    localparam logic [1:0] FCNT_INIT = FCNT_I[1:0];

    hz_state_e             r_state, w_state_nxt;
    logic [1:0]            r_fcnt, w_fcnt_nxt;
    logic                  r_pend, w_pend_nxt;
    logic [31:0]           r_stall_cnt;
    logic [NUM_SRC*SELW-1:0] w_sel;
    logic [NUM_SRC-1:0]    w_haz;
    logic                  w_dhaz;

    for (genvar n = 0; n < NUM_SRC; n++) begin : g_src
        fwd_select #(
            .REG_AW     (REG_AW),
            .FWD_STAGES (FWD_STAGES),
            .SELW       (SELW)
        ) u_fwd_select (
            .i_rs       (i_rs_addr[n*REG_AW +: REG_AW]),
            .i_need     (i_rs_need[n]),
            .i_prod_rd  (i_prod_rd),
            .i_prod_we  (i_prod_we),
            .i_prod_rdy (i_prod_rdy),
            .o_sel      (w_sel[n*SELW +: SELW]),
            .o_hazard   (w_haz[n])
        );
    end

    assign w_dhaz      = |w_haz;
    assign o_fwd_sel   = rst_n ? w_sel : '0;
    assign o_stall_cnt = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_fcnt  <= 2'd0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = ST_RUN;
        w_fcnt_nxt   = r_fcnt;
        w_pend_nxt   = r_pend;
        o_pc_stall   = 1'b0;
        o_ifid_stall = 1'b0;
        o_idex_stall = 1'b0;
        o_exma_stall = 1'b0;
        o_ifid_flush = 1'b0;
        o_idex_flush = 1'b0;
        o_exma_flush = 1'b0;
        o_mawb_flush = 1'b0;
        if (!rst_n) begin
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
            o_exma_flush = 1'b1;
            o_mawb_flush = 1'b1;
            w_pend_nxt   = 1'b0;
            w_fcnt_nxt   = 2'd0;
        end else if (i_dcache_miss) begin
            o_pc_stall   = 1'b1;
            o_ifid_stall = 1'b1;
            o_idex_stall = 1'b1;
            o_exma_stall = 1'b1;
            o_mawb_flush = 1'b1;
            w_state_nxt  = ST_DMISS;
            w_pend_nxt   = r_pend | i_mispredict;
        end else if (i_mispredict || r_pend) begin
            // A mispredict deferred by a dcache miss is replayed on the exit cycle.
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
            o_pc_stall   = i_icache_miss;
            w_pend_nxt   = 1'b0;
            w_fcnt_nxt   = FCNT_INIT;
            w_state_nxt  = (FLUSH_CYC > 1) ? ST_FLUSH : ST_RUN;
        end else if (r_state == ST_FLUSH) begin
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
            o_pc_stall   = i_icache_miss;
            if (r_fcnt == 2'd0) begin
                w_state_nxt = ST_RUN;
            end else begin
                w_state_nxt = ST_FLUSH;
                w_fcnt_nxt  = r_fcnt - 2'd1;
            end
        end else if (w_dhaz) begin
            o_pc_stall   = 1'b1;
            o_ifid_stall = 1'b1;
            o_idex_flush = 1'b1;
        end else if (i_icache_miss) begin
            o_pc_stall   = 1'b1;
            o_ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'd0;
        end else if (o_pc_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

endmodule
